// File: rtl/branch_predictor_gshare_btb.sv
`default_nettype none
// ============================================================================
// Module   : branch_predictor_gshare_btb
// Purpose  : Next-PC predictor: direct-mapped tagged BTB, gshare PHT indexed
//            by PC XOR global history, and a circular return address stack.
//            Lookup is combinational from registered state; training happens
//            non-speculatively from Execute.
// Revision : 1.0 - initial release
// ============================================================================
module branch_predictor_gshare_btb #(
  parameter int XLEN        = 64,
  parameter int BTB_ENTRIES = 64,
  parameter int TAG_BITS    = 10,
  parameter int GHR_BITS    = 8,
  parameter int RAS_DEPTH   = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [XLEN-1:0] PC,
  input  logic [XLEN-1:0] PCPlus4,
  output logic [XLEN-1:0] PCPrediction,
  output logic            predTaken,
  input  logic            we,
  input  logic [XLEN-1:0] PCUpdate,
  input  logic [XLEN-1:0] targetUpdate,
  input  logic            takenUpdate,
  input  logic [1:0]      typeUpdate
);

  localparam int IDX_W  = $clog2(BTB_ENTRIES);
  localparam int PHT_N  = 1 << GHR_BITS;
  localparam int RAS_W  = $clog2(RAS_DEPTH);
  localparam int TAG_LO = IDX_W + 2;
  localparam int TAG_HI = TAG_LO + TAG_BITS - 1;

  localparam logic [1:0] TYPE_BRANCH = 2'b00;
  localparam logic [1:0] TYPE_JUMP   = 2'b01;
  localparam logic [1:0] TYPE_CALL   = 2'b10;
  localparam logic [1:0] TYPE_RETURN = 2'b11;

  // Storage
  logic                btb_valid_q [BTB_ENTRIES];
  logic [TAG_BITS-1:0] btb_tag_q   [BTB_ENTRIES];
  logic [XLEN-1:0]     btb_tgt_q   [BTB_ENTRIES];
  logic [1:0]          btb_type_q  [BTB_ENTRIES];
  logic [1:0]          pht_q       [PHT_N];
  logic [XLEN-1:0]     ras_q       [RAS_DEPTH];
  logic [GHR_BITS-1:0] ghr_q, ghr_d;
  logic [RAS_W-1:0]    ras_ptr_q, ras_ptr_d;
  logic [RAS_W:0]      ras_cnt_q, ras_cnt_d;

  // Lookup-side decode
  logic [IDX_W-1:0]    lk_idx;
  logic [TAG_BITS-1:0] lk_tag;
  logic [GHR_BITS-1:0] lk_pht;
  logic [RAS_W-1:0]    ras_top;
  logic                lk_hit;

  assign lk_idx  = PC[IDX_W+1:2];
  assign lk_tag  = PC[TAG_HI:TAG_LO];
  assign lk_pht  = PC[GHR_BITS+1:2] ^ ghr_q;
  assign ras_top = ras_ptr_q - RAS_W'(1);
  assign lk_hit  = btb_valid_q[lk_idx] && (btb_tag_q[lk_idx] == lk_tag);

  // Update-side decode
  logic [IDX_W-1:0]    up_idx;
  logic [TAG_BITS-1:0] up_tag;
  logic [GHR_BITS-1:0] up_pht;
  logic                up_branch;
  logic                btb_wr;
  logic                ras_push;
  logic [1:0]          pht_cur;
  logic [1:0]          pht_d;

  assign up_idx    = PCUpdate[IDX_W+1:2];
  assign up_tag    = PCUpdate[TAG_HI:TAG_LO];
  assign up_pht    = PCUpdate[GHR_BITS+1:2] ^ ghr_q;
  assign up_branch = we && (typeUpdate == TYPE_BRANCH);
  assign btb_wr    = we && ((typeUpdate != TYPE_BRANCH) || takenUpdate);
  assign ras_push  = we && (typeUpdate == TYPE_CALL);
  assign pht_cur   = pht_q[up_pht];

  // PC bits outside the index/tag window do not participate in prediction
  logic unused_pc_bits;
  assign unused_pc_bits = ^{PC[XLEN-1:TAG_HI+1], PC[1:0],
                            PCUpdate[XLEN-1:TAG_HI+1], PCUpdate[1:0]};

  // Combinational next-PC selection; forced to fall-through while in reset
  always_comb begin
    PCPrediction = PCPlus4;
    predTaken    = 1'b0;
    if (!reset && lk_hit) begin
      case (btb_type_q[lk_idx])
        TYPE_BRANCH: begin
          if (pht_q[lk_pht][1]) begin
            PCPrediction = btb_tgt_q[lk_idx];
            predTaken    = 1'b1;
          end
        end
        TYPE_JUMP, TYPE_CALL: begin
          PCPrediction = btb_tgt_q[lk_idx];
          predTaken    = 1'b1;
        end
        default: begin
          PCPrediction = (ras_cnt_q != '0) ? ras_q[ras_top] : btb_tgt_q[lk_idx];
          predTaken    = 1'b1;
        end
      endcase
    end
  end

  // Next-state for the saturating counter, history register and RAS pointers
  always_comb begin
    pht_d     = pht_cur;
    ghr_d     = ghr_q;
    ras_ptr_d = ras_ptr_q;
    ras_cnt_d = ras_cnt_q;
    if (up_branch) begin
      if (takenUpdate && (pht_cur != 2'b11))
        pht_d = pht_cur + 2'b01;
      else if (!takenUpdate && (pht_cur != 2'b00))
        pht_d = pht_cur - 2'b01;
      ghr_d = {ghr_q[GHR_BITS-2:0], takenUpdate};
    end
    if (ras_push) begin
      ras_ptr_d = ras_ptr_q + RAS_W'(1);
      if (ras_cnt_q != (RAS_W+1)'(RAS_DEPTH))
        ras_cnt_d = ras_cnt_q + (RAS_W+1)'(1);
    end else if (we && (typeUpdate == TYPE_RETURN) && (ras_cnt_q != '0)) begin
      ras_ptr_d = ras_ptr_q - RAS_W'(1);
      ras_cnt_d = ras_cnt_q - (RAS_W+1)'(1);
    end
  end

  // BTB control fields: cleared on reset, replaced on every qualifying write
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < BTB_ENTRIES; i++) begin
        btb_valid_q[i] <= 1'b0;
        btb_tag_q[i]   <= '0;
        btb_type_q[i]  <= 2'b00;
      end
    end else if (btb_wr) begin
      btb_valid_q[up_idx] <= 1'b1;
      btb_tag_q[up_idx]   <= up_tag;
      btb_type_q[up_idx]  <= typeUpdate;
    end
  end

  // BTB targets need no reset: they are only read behind a valid bit
  always_ff @(posedge clk) begin
    if (!reset && btb_wr)
      btb_tgt_q[up_idx] <= targetUpdate;
  end

  // PHT counters start weakly not-taken and train only on conditional branches
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < PHT_N; i++)
        pht_q[i] <= 2'b01;
    end else if (up_branch) begin
      pht_q[up_pht] <= pht_d;
    end
  end

  // Global history and RAS bookkeeping
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ghr_q     <= '0;
      ras_ptr_q <= '0;
      ras_cnt_q <= '0;
    end else if (we) begin
      ghr_q     <= ghr_d;
      ras_ptr_q <= ras_ptr_d;
      ras_cnt_q <= ras_cnt_d;
    end
  end

  // RAS storage: a push writes the slot at the pointer, overwriting the oldest
  always_ff @(posedge clk) begin
    if (!reset && ras_push)
      ras_q[ras_ptr_q] <= PCUpdate + XLEN'(4);
  end

endmodule
`default_nettype wire

// File: tb/tb_branch_predictor_gshare_btb.sv
`default_nettype none
// ============================================================================
// Module   : tb_branch_predictor_gshare_btb
// Purpose  : Scoreboard bench for branch_predictor_gshare_btb. A driver issues
//            one lookup (optionally with an update) per cycle and queues the
//            reference-model prediction; a monitor pops and compares.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_branch_predictor_gshare_btb;

  localparam int XLEN        = 64;
  localparam int BTB_ENTRIES = 64;
  localparam int TAG_BITS    = 10;
  localparam int GHR_BITS    = 8;
  localparam int RAS_DEPTH   = 8;
  localparam int PHT_N       = 1 << GHR_BITS;
  localparam int IDX_W       = $clog2(BTB_ENTRIES);

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic [XLEN-1:0] PC = '0;
  logic [XLEN-1:0] PCPlus4 = 64'd4;
  logic [XLEN-1:0] PCPrediction;
  logic            predTaken;
  logic            we = 1'b0;
  logic [XLEN-1:0] PCUpdate = '0;
  logic [XLEN-1:0] targetUpdate = '0;
  logic            takenUpdate = 1'b0;
  logic [1:0]      typeUpdate = 2'b00;

  always #5 clk = ~clk;

  branch_predictor_gshare_btb #(
    .XLEN(XLEN), .BTB_ENTRIES(BTB_ENTRIES), .TAG_BITS(TAG_BITS),
    .GHR_BITS(GHR_BITS), .RAS_DEPTH(RAS_DEPTH)
  ) dut (
    .clk(clk), .reset(reset), .PC(PC), .PCPlus4(PCPlus4),
    .PCPrediction(PCPrediction), .predTaken(predTaken), .we(we),
    .PCUpdate(PCUpdate), .targetUpdate(targetUpdate),
    .takenUpdate(takenUpdate), .typeUpdate(typeUpdate)
  );

  // ---------------- reference model ----------------
  bit              m_valid [BTB_ENTRIES];
  longint unsigned m_tag   [BTB_ENTRIES];
  logic [63:0]     m_tgt   [BTB_ENTRIES];
  int              m_type  [BTB_ENTRIES];
  int              m_pht   [PHT_N];
  int              m_ghr;
  logic [63:0]     m_ras   [$];

  function automatic int m_idx(input logic [63:0] pc);
    return int'((pc >> 2) % BTB_ENTRIES);
  endfunction

  function automatic longint unsigned m_tagof(input logic [63:0] pc);
    return (pc >> (2 + IDX_W)) % (64'd1 << TAG_BITS);
  endfunction

  function automatic int m_phtidx(input logic [63:0] pc);
    return int'((pc >> 2) % PHT_N) ^ m_ghr;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < BTB_ENTRIES; i++) m_valid[i] = 0;
    for (int i = 0; i < PHT_N; i++) m_pht[i] = 1;
    m_ghr = 0;
    m_ras.delete();
  endtask

  task automatic model_predict(input logic [63:0] pc, output logic [63:0] p, output logic t);
    int i;
    i = m_idx(pc);
    p = pc + 64'd4;
    t = 1'b0;
    if (m_valid[i] && m_tag[i] == m_tagof(pc)) begin
      if (m_type[i] == 0) begin
        if (m_pht[m_phtidx(pc)] >= 2) begin p = m_tgt[i]; t = 1'b1; end
      end else if (m_type[i] == 3) begin
        p = (m_ras.size() > 0) ? m_ras[$] : m_tgt[i];
        t = 1'b1;
      end else begin
        p = m_tgt[i];
        t = 1'b1;
      end
    end
  endtask

  task automatic model_update(input logic [63:0] pcu, input logic [63:0] tgt,
                              input logic tk, input int ty);
    int i, pi;
    i = m_idx(pcu);
    if (ty == 0) begin
      pi = m_phtidx(pcu);
      if (tk && m_pht[pi] < 3) m_pht[pi]++;
      if (!tk && m_pht[pi] > 0) m_pht[pi]--;
      m_ghr = ((m_ghr << 1) | int'(tk)) % PHT_N;
    end
    if (ty != 0 || tk) begin
      m_valid[i] = 1;
      m_tag[i]   = m_tagof(pcu);
      m_tgt[i]   = tgt;
      m_type[i]  = ty;
    end
    if (ty == 2) begin
      m_ras.push_back(pcu + 64'd4);
      if (m_ras.size() > RAS_DEPTH) void'(m_ras.pop_front());
    end else if (ty == 3 && m_ras.size() > 0) begin
      void'(m_ras.pop_back());
    end
  endtask

  // ---------------- scoreboard ----------------
  typedef struct {
    logic [63:0] pc;
    logic [63:0] pred;
    logic        taken;
    int          id;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;
  int   n_issued = 0;

  // One fetch-cycle: drive lookup and optional update, queue the expectation
  task automatic step(input logic [63:0] pc, input logic w, input logic [63:0] pcu,
                      input logic [63:0] tgt, input logic tk, input logic [1:0] ty,
                      input logic rst_in);
    exp_t e;
    @(posedge clk);
    #1;
    reset = rst_in;
    PC = pc; PCPlus4 = pc + 64'd4;
    we = w; PCUpdate = pcu; targetUpdate = tgt; takenUpdate = tk; typeUpdate = ty;
    e.pc = pc;
    e.id = n_issued;
    if (rst_in) begin
      model_reset();
      e.pred  = pc + 64'd4;
      e.taken = 1'b0;
    end else begin
      model_predict(pc, e.pred, e.taken);
      if (w) model_update(pcu, tgt, tk, int'(ty));
    end
    n_issued++;
    sb.push_back(e);
  endtask

  task automatic lookup(input logic [63:0] pc);
    step(pc, 1'b0, 64'd0, 64'd0, 1'b0, 2'b00, 1'b0);
  endtask

  task automatic upd(input logic [63:0] pc, input logic [63:0] pcu, input logic [63:0] tgt,
                     input logic tk, input logic [1:0] ty);
    step(pc, 1'b1, pcu, tgt, tk, ty, 1'b0);
  endtask

  // Monitor: prediction is valid every cycle; compare away from the clock edge
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      checks++;
      if (PCPrediction !== e.pred || predTaken !== e.taken) begin
        failures++;
        $display("FAIL lookup#%0d pc=%h got pred=%h taken=%b expected pred=%h taken=%b",
                 e.id, e.pc, PCPrediction, predTaken, e.pred, e.taken);
      end
    end
  end

  // Watchdog
  initial begin
    #500000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

  logic [63:0] pool [24];

  initial begin
    // Reset state
    step(64'h100, 1'b0, 0, 0, 0, 2'b00, 1'b1);
    step(64'h100, 1'b0, 0, 0, 0, 2'b00, 1'b1);
    lookup(64'h100);

    // Plain jump training and a neighbouring miss
    upd(64'h200, 64'h200, 64'h300, 1'b1, 2'b01);
    lookup(64'h200);
    lookup(64'h204);

    // Gshare: nine taken branches, with a lookup after the first
    upd(64'h240, 64'h240, 64'h180, 1'b1, 2'b00);
    lookup(64'h240);
    for (int k = 0; k < 8; k++) upd(64'h240, 64'h240, 64'h180, 1'b1, 2'b00);
    lookup(64'h240);

    // Return predicted from the call stack, then from the BTB after the pop
    upd(64'h508, 64'h508, 64'h999, 1'b1, 2'b11);
    upd(64'h508, 64'h400, 64'h800, 1'b1, 2'b10);
    lookup(64'h508);
    upd(64'h508, 64'h508, 64'h999, 1'b1, 2'b11);
    lookup(64'h508);

    // RAS overflow by one, then drain past empty
    for (int k = 0; k < 9; k++) upd(64'h508, 64'h1000 + 64'(k) * 64'h10, 64'h2000, 1'b1, 2'b10);
    for (int k = 0; k < 9; k++) upd(64'h508, 64'h508, 64'h999, 1'b1, 2'b11);
    lookup(64'h508);

    // BTB conflict replacement
    upd(64'h200, 64'h200, 64'h300, 1'b1, 2'b01);
    upd(64'h200, 64'h200 + BTB_ENTRIES * 4, 64'h700, 1'b1, 2'b01);
    lookup(64'h200);
    lookup(64'h200 + BTB_ENTRIES * 4);

    // Reset mid-run with an update presented in the same cycle
    step(64'h240, 1'b1, 64'h240, 64'h180, 1'b1, 2'b01, 1'b1);
    lookup(64'h240);
    lookup(64'h508);
    lookup(64'h100);

    // Randomised traffic over a small PC pool so hits and conflicts occur
    for (int k = 0; k < 24; k++) pool[k] = 64'($urandom_range(0, 1023)) * 64'd4;
    for (int k = 0; k < 600; k++) begin
      logic [63:0] lpc, upc, tgt;
      lpc = pool[$urandom_range(0, 23)];
      upc = pool[$urandom_range(0, 23)];
      tgt = 64'($urandom()) & ~64'd3;
      if ($urandom_range(0, 199) == 0)
        step(lpc, 1'b1, upc, tgt, 1'b1, 2'b01, 1'b1);
      else
        step(lpc, 1'($urandom_range(0, 9) < 7), upc, tgt,
             1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'b0);
    end

    // Drain the scoreboard
    @(posedge clk);
    #1;
    we = 1'b0;
    repeat (2) @(posedge clk);
    if (sb.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL drain pending=%0d expected=0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
